// File: rtl/clk_div_prog.sv
// Programmable multi-channel tick/clock divider with a stretched reset-release sequencer.
// Latency: outputs registered; first tick D+1 cycles after the enabling write, resetn rises RST_HOLD cycles after RESET drops.
// Backpressure: none; config writes are accepted every cycle RESET is low, writes to absent channels are dropped.
module clk_div_prog #(
  parameter int NCH      = 2,
  parameter int DIV_W    = 16,
  parameter int RST_HOLD = 16
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]                  cfg_div,
  input  logic                              cfg_en,
  output logic [NCH-1:0]                    clk_out,
  output logic [NCH-1:0]                    tick,
  output logic                              resetn
);

  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt;

  // Reset stretcher: count clean cycles after RESET drops, then release resetn and hold it high.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hold_cnt <= '0;
      resetn   <= 1'b0;
    end else if (!resetn) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
      if (hold_cnt == HOLD_LAST) begin
        resetn <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // Channel indices that do not exist never match, so out-of-range writes fall through untouched.
    localparam logic [CH_W-1:0] IDX = CH_W'(i);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] d_act;
    logic [DIV_W-1:0] d_shd;
    logic             en;
    logic             clk_q;
    logic             tick_q;
    logic             wr_hit;

    assign wr_hit = cfg_we && (cfg_ch == IDX);

    // Per-channel divider: write handling first, then the free-running count that swaps in the shadow divisor only at wrap.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        cnt    <= '0;
        d_act  <= '0;
        d_shd  <= '0;
        en     <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (wr_hit && !cfg_en) begin
        // Disable parks the outputs low but still captures the divisor for a later enable.
        cnt    <= '0;
        d_act  <= cfg_div;
        d_shd  <= cfg_div;
        en     <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (wr_hit && !en) begin
        // Enabling a stopped channel loads the divisor directly and starts a fresh period.
        cnt   <= '0;
        d_act <= cfg_div;
        d_shd <= cfg_div;
        en    <= 1'b1;
      end else begin
        // Retune of a running channel only touches the shadow so the current period completes untouched.
        if (wr_hit) begin
          d_shd <= cfg_div;
        end
        if (en) begin
          if (cnt == d_act) begin
            cnt    <= '0;
            tick_q <= 1'b1;
            clk_q  <= ~clk_q;
            d_act  <= d_shd;
          end else begin
            cnt    <= cnt + DIV_W'(1);
            tick_q <= 1'b0;
          end
        end
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: reset stretching, divide ratios, retune, disable, bad channel, reset precedence.
// Inputs are driven and outputs sampled on the falling edge, away from the active rising edge.
// Three channels are built so that channel index 3 is representable but out of range.
module tb_clk_div_prog;

  localparam int NCH      = 3;
  localparam int DIV_W    = 4;
  localparam int RST_HOLD = 16;

  logic             clk;
  logic             reset;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_en;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic             resetn;

  int checks;
  int errors;

  clk_div_prog #(
    .NCH(NCH),
    .DIV_W(DIV_W),
    .RST_HOLD(RST_HOLD)
  ) dut (
    .CLK(clk),
    .RESET(reset),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_en(cfg_en),
    .clk_out(clk_out),
    .tick(tick),
    .resetn(resetn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle config write; returns at the falling edge right after the write edge.
  task automatic wr(input logic [1:0] ch, input logic [DIV_W-1:0] dv, input logic en);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_div = dv;
    cfg_en  = en;
    @(negedge clk);
    cfg_we  = 1'b0;
  endtask

  task automatic test_reset;
    logic exp;
    reset = 1'b1;
    step(5);
    checks++;
    if (resetn !== 1'b0 || clk_out !== 3'b000 || tick !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: resetn=%b clk_out=%b tick=%b, want 0/000/000", resetn, clk_out, tick);
    end
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      exp = (k >= 16);
      checks++;
      if (resetn !== exp) begin
        errors++;
        $display("FAIL reset_hold k=%0d: resetn=%b want %b", k, resetn, exp);
      end
    end
    // Restart mid-count: pulse RESET after 10 clean cycles.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(10);
    reset = 1'b1;
    step(1);
    checks++;
    if (resetn !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse: resetn=%b want 0", resetn);
    end
    reset = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step(1);
      exp = (k >= 16);
      checks++;
      if (resetn !== exp) begin
        errors++;
        $display("FAIL reset_restart k=%0d: resetn=%b want %b", k, resetn, exp);
      end
    end
  endtask

  task automatic test_basic;
    logic et, ec;
    wr(2'd0, 4'd3, 1'b1);
    for (int c = 0; c <= 16; c++) begin
      et = (c >= 4) && (c % 4 == 0);
      ec = (c >= 4) && ((c / 4) % 2 == 1);
      checks++;
      if (tick[0] !== et || clk_out[0] !== ec || tick[2:1] !== 2'b00 || clk_out[2:1] !== 2'b00) begin
        errors++;
        $display("FAIL basic c=%0d: tick=%b clk_out=%b want tick0=%b clk0=%b others 0", c, tick, clk_out, et, ec);
      end
      step(1);
    end
  endtask

  task automatic test_d0_max;
    logic et, ec;
    wr(2'd1, 4'd0, 1'b1);
    for (int c = 0; c <= 6; c++) begin
      et = (c >= 1);
      ec = (c % 2 == 1);
      checks++;
      if (tick[1] !== et || clk_out[1] !== ec) begin
        errors++;
        $display("FAIL d0 c=%0d: tick1=%b clk1=%b want %b %b", c, tick[1], clk_out[1], et, ec);
      end
      step(1);
    end
    wr(2'd2, 4'd15, 1'b1);
    for (int c = 0; c <= 33; c++) begin
      et = (c > 0) && (c % 16 == 0);
      ec = (c >= 16) && (c < 32);
      checks++;
      if (tick[2] !== et || clk_out[2] !== ec) begin
        errors++;
        $display("FAIL dmax c=%0d: tick2=%b clk2=%b want %b %b", c, tick[2], clk_out[2], et, ec);
      end
      step(1);
    end
    wr(2'd1, 4'd0, 1'b0);
    wr(2'd2, 4'd0, 1'b0);
  endtask

  task automatic test_reprogram;
    logic et;
    wr(2'd0, 4'd0, 1'b0);
    wr(2'd0, 4'd7, 1'b1);
    step(2);
    wr(2'd0, 4'd1, 1'b1);
    for (int d = 0; d <= 11; d++) begin
      et = (d >= 5) && ((d - 5) % 2 == 0);
      checks++;
      if (tick[0] !== et) begin
        errors++;
        $display("FAIL reprogram d=%0d: tick0=%b want %b", d, tick[0], et);
      end
      step(1);
    end
  endtask

  task automatic test_disable;
    wr(2'd0, 4'd0, 1'b0);
    wr(2'd0, 4'd3, 1'b1);
    step(5);
    checks++;
    if (clk_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL disable_pre: clk0=%b want 1", clk_out[0]);
    end
    wr(2'd0, 4'd3, 1'b0);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
        errors++;
        $display("FAIL disable c=%0d: clk0=%b tick0=%b want 0 0", c, clk_out[0], tick[0]);
      end
      step(1);
    end
  endtask

  task automatic test_invalid_ch;
    logic et, ec;
    wr(2'd1, 4'd2, 1'b1);
    step(4);
    wr(2'd3, 4'd0, 1'b0);
    for (int c = 5; c <= 13; c++) begin
      et = (c % 3 == 0);
      ec = ((c / 3) % 2 == 1);
      checks++;
      if (tick !== {1'b0, et, 1'b0} || clk_out !== {1'b0, ec, 1'b0}) begin
        errors++;
        $display("FAIL invalid_ch c=%0d: tick=%b clk_out=%b want %b %b", c, tick, clk_out, {1'b0, et, 1'b0}, {1'b0, ec, 1'b0});
      end
      step(1);
    end
  endtask

  task automatic test_reset_prec;
    reset   = 1'b1;
    cfg_we  = 1'b1;
    cfg_ch  = 2'd0;
    cfg_div = 4'd5;
    cfg_en  = 1'b1;
    step(1);
    reset  = 1'b0;
    cfg_we = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (tick !== 3'b000 || clk_out !== 3'b000) begin
        errors++;
        $display("FAIL reset_prec c=%0d: tick=%b clk_out=%b want 000 000", c, tick, clk_out);
      end
      step(1);
    end
    checks++;
    if (resetn !== 1'b0) begin
      errors++;
      $display("FAIL reset_prec_resetn: resetn=%b want 0", resetn);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;
    cfg_en  = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_d0_max();
    test_reprogram();
    test_disable();
    test_invalid_ch();
    test_reset_prec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
